// File: rtl/nco_cfg_ctrl_if.sv
// Byte-stream side of the NCO configuration block: frame delimiters and
// received bytes as delivered by an I2C slave front end.
interface nco_cfg_ctrl_if;
    logic       frame_start;
    logic       frame_stop;
    logic       rx_valid;
    logic [7:0] rx_data;

    modport master (
        output frame_start,
        output frame_stop,
        output rx_valid,
        output rx_data
    );

    modport slave (
        input  frame_start,
        input  frame_stop,
        input  rx_valid,
        input  rx_data
    );
endinterface

// File: rtl/nco_cfg_ctrl.sv
// NCO configuration controller: parses ctrl/frequency/duty frames into shadow
// registers and commits them atomically on stop. Duty support: NCO_CFG_DUTY_EN.
module nco_cfg_ctrl #(
    parameter logic [63:0] FREQ_RST = 64'h0,
    parameter logic [15:0] DUTY_RST = 16'h8000
) (
    input  logic                 clk,
    input  logic                 rst,
    nco_cfg_ctrl_if.slave        rx,
    output logic                 nco_enable,
    output logic [1:0]           wave,
    output logic [63:0]          frequency,
    output logic [15:0]          duty_cycle,
    output logic                 cfg_update,
    output logic                 cfg_error,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CTRL = 3'd1,
        FREQ = 3'd2,
        DUTY = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    state_t      rx_state;
    logic [2:0]  cnt_q, cnt_d;

    logic        sh_en_q, sh_en_d;
    logic [1:0]  sh_wave_q, sh_wave_d;
    logic        sh_freq_flag_q, sh_freq_flag_d;
    logic [63:0] sh_freq_q, sh_freq_d;

    logic        en_q, en_d;
    logic [1:0]  wave_q, wave_d;
    logic [63:0] freq_q, freq_d;
    logic        upd_q, upd_d;
    logic        err_q, err_d;

`ifdef NCO_CFG_DUTY_EN
    logic        sh_duty_flag_q, sh_duty_flag_d;
    logic [15:0] sh_duty_q, sh_duty_d;
    logic [15:0] duty_q, duty_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= 3'd0;
            sh_en_q        <= 1'b0;
            sh_wave_q      <= 2'b00;
            sh_freq_flag_q <= 1'b0;
            sh_freq_q      <= 64'h0;
            en_q           <= 1'b0;
            wave_q         <= 2'b00;
            freq_q         <= FREQ_RST;
            upd_q          <= 1'b0;
            err_q          <= 1'b0;
`ifdef NCO_CFG_DUTY_EN
            sh_duty_flag_q <= 1'b0;
            sh_duty_q      <= 16'h0;
            duty_q         <= DUTY_RST;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sh_en_q        <= sh_en_d;
            sh_wave_q      <= sh_wave_d;
            sh_freq_flag_q <= sh_freq_flag_d;
            sh_freq_q      <= sh_freq_d;
            en_q           <= en_d;
            wave_q         <= wave_d;
            freq_q         <= freq_d;
            upd_q          <= upd_d;
            err_q          <= err_d;
`ifdef NCO_CFG_DUTY_EN
            sh_duty_flag_q <= sh_duty_flag_d;
            sh_duty_q      <= sh_duty_d;
            duty_q         <= duty_d;
`endif
        end
    end

    // The byte is consumed first (rx_state), then a same-cycle stop is judged
    // against that post-byte state so the final byte and stop can coincide.
    always_comb begin
        state_d        = state_q;
        rx_state       = state_q;
        cnt_d          = cnt_q;
        sh_en_d        = sh_en_q;
        sh_wave_d      = sh_wave_q;
        sh_freq_flag_d = sh_freq_flag_q;
        sh_freq_d      = sh_freq_q;
        en_d           = en_q;
        wave_d         = wave_q;
        freq_d         = freq_q;
        upd_d          = 1'b0;
        err_d          = err_q;
`ifdef NCO_CFG_DUTY_EN
        sh_duty_flag_d = sh_duty_flag_q;
        sh_duty_d      = sh_duty_q;
        duty_d         = duty_q;
`endif

        if (rx.frame_start) begin
            state_d        = CTRL;
            rx_state       = CTRL;
            cnt_d          = 3'd0;
            sh_en_d        = 1'b0;
            sh_wave_d      = 2'b00;
            sh_freq_flag_d = 1'b0;
            sh_freq_d      = 64'h0;
            err_d          = 1'b0;
`ifdef NCO_CFG_DUTY_EN
            sh_duty_flag_d = 1'b0;
            sh_duty_d      = 16'h0;
`endif
        end else begin
            if (rx.rx_valid) begin
                case (state_q)
                    CTRL: begin
                        sh_en_d        = rx.rx_data[0];
                        sh_wave_d      = rx.rx_data[2:1];
                        sh_freq_flag_d = rx.rx_data[4];
`ifdef NCO_CFG_DUTY_EN
                        sh_duty_flag_d = rx.rx_data[5];
                        if (rx.rx_data[4]) begin
                            rx_state = FREQ;
                        end else if (rx.rx_data[5]) begin
                            rx_state = DUTY;
                        end else begin
                            rx_state = DONE;
                        end
`else
                        rx_state = rx.rx_data[4] ? FREQ : DONE;
`endif
                    end
                    FREQ: begin
                        sh_freq_d = {sh_freq_q[55:0], rx.rx_data};
                        cnt_d     = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
`ifdef NCO_CFG_DUTY_EN
                            rx_state = sh_duty_flag_q ? DUTY : DONE;
`else
                            rx_state = DONE;
`endif
                        end
                    end
`ifdef NCO_CFG_DUTY_EN
                    DUTY: begin
                        sh_duty_d = {sh_duty_q[7:0], rx.rx_data};
                        if (cnt_q == 3'd1) begin
                            cnt_d    = 3'd0;
                            rx_state = DONE;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
`endif
                    DONE: begin
                        rx_state = ERR;
                        err_d    = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            state_d = rx_state;

            if (rx.frame_stop) begin
                case (rx_state)
                    DONE: begin
                        en_d   = sh_en_d;
                        wave_d = sh_wave_d;
                        if (sh_freq_flag_d) begin
                            freq_d = sh_freq_d;
                        end
`ifdef NCO_CFG_DUTY_EN
                        if (sh_duty_flag_d) begin
                            duty_d = sh_duty_d;
                        end
`endif
                        upd_d   = 1'b1;
                        cnt_d   = 3'd0;
                        state_d = IDLE;
                    end
                    FREQ, DUTY: begin
                        err_d   = 1'b1;
                        cnt_d   = 3'd0;
                        state_d = IDLE;
                    end
                    CTRL, ERR: begin
                        cnt_d   = 3'd0;
                        state_d = IDLE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign nco_enable = en_q;
    assign wave       = wave_q;
    assign frequency  = freq_q;
    assign cfg_update = upd_q;
    assign cfg_error  = err_q;
    assign busy       = (state_q != IDLE);

`ifdef NCO_CFG_DUTY_EN
    assign duty_cycle = duty_q;
`else
    assign duty_cycle = DUTY_RST;
`endif

endmodule

// File: tb/tb_nco_cfg_ctrl.sv
// Self-checking bench for nco_cfg_ctrl: directed table, hand sequences for the
// multi-cycle corner cases, then random frames against a frame-level model.
module tb_nco_cfg_ctrl;

    localparam logic [63:0] FREQ_RST = 64'h0;
    localparam logic [15:0] DUTY_RST = 16'h8000;
`ifdef NCO_CFG_DUTY_EN
    localparam bit DUTY_ON = 1'b1;
`else
    localparam bit DUTY_ON = 1'b0;
`endif
    localparam logic [63:0] F035 = 64'h0001_D4C0_0000_0000;
    localparam logic [63:0] F037 = 64'h0000_0002_0000_0000;
    localparam logic [63:0] F_AFTER_037 = DUTY_ON ? F037 : F035;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        nco_enable;
    logic [1:0]  wave;
    logic [63:0] frequency;
    logic [15:0] duty_cycle;
    logic        cfg_update;
    logic        cfg_error;
    logic        busy;

    nco_cfg_ctrl_if bus ();

    nco_cfg_ctrl #(
        .FREQ_RST (FREQ_RST),
        .DUTY_RST (DUTY_RST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (bus.slave),
        .nco_enable (nco_enable),
        .wave       (wave),
        .frequency  (frequency),
        .duty_cycle (duty_cycle),
        .cfg_update (cfg_update),
        .cfg_error  (cfg_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Frame-level reference: collects the bytes of the open frame and judges
    // the whole frame against its required length when the stop arrives.
    logic        m_open, m_err, m_en, m_upd;
    logic [1:0]  m_wave;
    logic [63:0] m_freq;
    logic [15:0] m_duty;
    logic [7:0]  m_bytes[$];

    function automatic int need_len(input logic [7:0] c);
        int n = 1;
        if (c[4]) n += 8;
        if (DUTY_ON && c[5]) n += 2;
        return n;
    endfunction

    task automatic model_reset();
        m_open = 1'b0; m_err = 1'b0; m_en = 1'b0; m_upd = 1'b0;
        m_wave = 2'b00; m_freq = FREQ_RST; m_duty = DUTY_RST;
        m_bytes.delete();
    endtask

    task automatic model_step(input logic st, input logic sp, input logic vld, input logic [7:0] d);
        int n;
        int idx;
        logic [7:0] c;
        m_upd = 1'b0;
        if (st) begin
            m_open = 1'b1;
            m_err  = 1'b0;
            m_bytes.delete();
        end else begin
            if (vld && m_open) begin
                m_bytes.push_back(d);
                if (m_bytes.size() > need_len(m_bytes[0])) m_err = 1'b1;
            end
            if (sp && m_open) begin
                m_open = 1'b0;
                if (m_bytes.size() > 0) begin
                    c = m_bytes[0];
                    n = need_len(c);
                    if (m_bytes.size() < n) begin
                        m_err = 1'b1;
                    end else if (m_bytes.size() == n) begin
                        m_en   = c[0];
                        m_wave = c[2:1];
                        idx = 1;
                        if (c[4]) begin
                            for (int k = 0; k < 8; k++) m_freq = {m_freq[55:0], m_bytes[1+k]};
                            idx = 9;
                        end
                        if (DUTY_ON && c[5]) m_duty = {m_bytes[idx], m_bytes[idx+1]};
                        m_upd = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic cmp_model();
        chk("nco_enable", {63'h0, nco_enable}, {63'h0, m_en});
        chk("wave",       {62'h0, wave},       {62'h0, m_wave});
        chk("frequency",  frequency,           m_freq);
        chk("duty_cycle", {48'h0, duty_cycle}, {48'h0, m_duty});
        chk("cfg_update", {63'h0, cfg_update}, {63'h0, m_upd});
        chk("cfg_error",  {63'h0, cfg_error},  {63'h0, m_err});
        chk("busy",       {63'h0, busy},       {63'h0, m_open});
    endtask

    // Drives one clock's worth of inputs from a negedge and returns at the next negedge.
    task automatic cycle(input logic st, input logic sp, input logic vld, input logic [7:0] d);
        bus.frame_start = st;
        bus.frame_stop  = sp;
        bus.rx_valid    = vld;
        bus.rx_data     = d;
        @(posedge clk);
        model_step(st, sp, vld, d);
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.frame_stop  = 1'b0;
        bus.rx_valid    = 1'b0;
        cmp_model();
    endtask

    task automatic send_freq(input logic [63:0] f);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, f[63-8*i -: 8]);
    endtask

    typedef struct {
        logic        st, sp, vld;
        logic [7:0]  d;
        logic        en;
        logic [1:0]  wv;
        logic [63:0] fq;
        logic [15:0] dy;
        logic        upd, err, bsy;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 64'h0, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 2'b00, 64'h0, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 64'h0, 16'h8000, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 64'h0, 16'h8000, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 2'b10, 64'h0, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 64'h0, 16'h8000, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 64'h0, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 2'b10, 64'h0, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 2'b10, 64'h0, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 2'b10, 64'h0, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 2'b10, 64'h0, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 64'h0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 64'h0, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 2'b00, 64'h0, 16'h8000, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 2'b00, 64'h0, 16'h8000, 1'b0, 1'b0, 1'b0};

        bus.frame_start = 1'b0;
        bus.frame_stop  = 1'b0;
        bus.rx_valid    = 1'b0;
        bus.rx_data     = 8'h00;
        model_reset();

        // Reset state while rst is held low.
        #3;
        chk("rst nco_enable", {63'h0, nco_enable}, 64'h0);
        chk("rst wave",       {62'h0, wave},       64'h0);
        chk("rst frequency",  frequency,           FREQ_RST);
        chk("rst duty_cycle", {48'h0, duty_cycle}, {48'h0, DUTY_RST});
        chk("rst cfg_update", {63'h0, cfg_update}, 64'h0);
        chk("rst cfg_error",  {63'h0, cfg_error},  64'h0);
        chk("rst busy",       {63'h0, busy},       64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed table: ctrl-only commit, dropped byte on start, address-only
        // frame, truncated frequency, byte and stop in the same cycle.
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].st, tbl[i].sp, tbl[i].vld, tbl[i].d);
            $display("vec %0d: start=%0b stop=%0b valid=%0b data=%h -> en=%0b wave=%0d upd=%0b err=%0b busy=%0b",
                     i, tbl[i].st, tbl[i].sp, tbl[i].vld, tbl[i].d, nco_enable, wave, cfg_update, cfg_error, busy);
            chk($sformatf("tbl%0d nco_enable", i), {63'h0, nco_enable}, {63'h0, tbl[i].en});
            chk($sformatf("tbl%0d wave", i),       {62'h0, wave},       {62'h0, tbl[i].wv});
            chk($sformatf("tbl%0d frequency", i),  frequency,           tbl[i].fq);
            chk($sformatf("tbl%0d duty_cycle", i), {48'h0, duty_cycle}, {48'h0, tbl[i].dy});
            chk($sformatf("tbl%0d cfg_update", i), {63'h0, cfg_update}, {63'h0, tbl[i].upd});
            chk($sformatf("tbl%0d cfg_error", i),  {63'h0, cfg_error},  {63'h0, tbl[i].err});
            chk($sformatf("tbl%0d busy", i),       {63'h0, busy},       {63'h0, tbl[i].bsy});
        end

        // Full frequency frame.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h11);
        send_freq(F035);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        $display("seq freq: en=%0b wave=%0d freq=%h upd=%0b", nco_enable, wave, frequency, cfg_update);
        chk("freq nco_enable", {63'h0, nco_enable}, 64'h1);
        chk("freq wave",       {62'h0, wave},       64'h0);
        chk("freq frequency",  frequency,           F035);
        chk("freq cfg_update", {63'h0, cfg_update}, 64'h1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk("freq update width", {63'h0, cfg_update}, 64'h0);

        // Frequency plus duty frame.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h31);
        send_freq(F037);
        cycle(1'b0, 1'b0, 1'b1, 8'h40);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        $display("seq duty: freq=%h duty=%h upd=%0b err=%0b", frequency, duty_cycle, cfg_update, cfg_error);
        chk("duty frequency",  frequency,           F_AFTER_037);
        chk("duty duty_cycle", {48'h0, duty_cycle}, DUTY_ON ? 64'h4000 : {48'h0, DUTY_RST});
        chk("duty cfg_update", {63'h0, cfg_update}, DUTY_ON ? 64'h1 : 64'h0);
        chk("duty cfg_error",  {63'h0, cfg_error},  DUTY_ON ? 64'h0 : 64'h1);

        // Repeated start abandons a half-received frequency.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'h00);
        chk("rs pre nco_enable", {63'h0, nco_enable}, 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h11);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 8'hFF);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h01);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        $display("seq rstart: en=%0b freq=%h upd=%0b err=%0b", nco_enable, frequency, cfg_update, cfg_error);
        chk("rs nco_enable", {63'h0, nco_enable}, 64'h1);
        chk("rs frequency",  frequency,           F_AFTER_037);
        chk("rs cfg_update", {63'h0, cfg_update}, 64'h1);
        chk("rs cfg_error",  {63'h0, cfg_error},  64'h0);

        // Asynchronous reset in the middle of a frequency frame.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h11);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'h12);
        #2 rst = 1'b0;
        #1;
        $display("seq midreset: en=%0b freq=%h busy=%0b", nco_enable, frequency, busy);
        chk("mr nco_enable", {63'h0, nco_enable}, 64'h0);
        chk("mr wave",       {62'h0, wave},       64'h0);
        chk("mr frequency",  frequency,           FREQ_RST);
        chk("mr duty_cycle", {48'h0, duty_cycle}, {48'h0, DUTY_RST});
        chk("mr busy",       {63'h0, busy},       64'h0);
        chk("mr cfg_error",  {63'h0, cfg_error},  64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'h12);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("mr cfg_update", {63'h0, cfg_update}, 64'h0);
        chk("mr frequency after", frequency, FREQ_RST);

        // Random frames: exact, truncated, over-long, address-only, repeated start.
        for (int f = 0; f < 300; f++) begin
            logic [7:0] c;
            int n;
            int len;
            int kind;
            bit stop_sent;
            c = 8'($urandom);
            n = need_len(c);
            kind = int'($urandom_range(0, 7));
            if (kind == 0)      len = 0;
            else if (kind == 1) len = int'($urandom_range(1, n));
            else if (kind == 2) len = n + int'($urandom_range(1, 2));
            else                len = n;
            stop_sent = 1'b0;
            cycle(1'b1, 1'b0, ($urandom_range(0, 1) == 1), 8'($urandom));
            for (int b = 0; b < len; b++) begin
                logic [7:0] d;
                bit last;
                d = (b == 0) ? c : 8'($urandom);
                last = (b == len - 1);
                if ($urandom_range(0, 2) == 0) cycle(1'b0, 1'b0, 1'b0, 8'($urandom));
                if (last && $urandom_range(0, 2) == 0) begin
                    cycle(1'b0, 1'b1, 1'b1, d);
                    stop_sent = 1'b1;
                end else begin
                    cycle(1'b0, 1'b0, 1'b1, d);
                end
            end
            if (!stop_sent && $urandom_range(0, 7) != 0) cycle(1'b0, 1'b1, 1'b0, 8'h00);
            $display("frame %0d: ctrl=%h bytes=%0d need=%0d -> en=%0b wave=%0d freq=%h duty=%h err=%0b",
                     f, c, len, n, nco_enable, wave, frequency, duty_cycle, cfg_error);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                cycle(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nco_cfg_ctrl.md
NCO_CFG_CTRL -- requirements
Module: nco_cfg_ctrl

Interface
REQ-001 Parameter FREQ_RST, default 64'h0: frequency word loaded at reset.
REQ-002 Parameter DUTY_RST, default 16'h8000: duty word loaded at reset.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 frame_start  input  1  one-cycle pulse: I2C slave matched address (write) or saw repeated start.
REQ-006 frame_stop  input  1  one-cycle pulse: I2C stop condition seen.
REQ-007 rx_valid  input  1  one-cycle pulse: rx_data holds a received byte.
REQ-008 rx_data  input  8  received byte, MSB first on the wire.
REQ-009 nco_enable  output  1  committed NCO enable.
REQ-010 wave  output  2  committed waveform select.
REQ-011 frequency  output  64  committed phase increment, 32.32 fixed point.
REQ-012 duty_cycle  output  16  committed duty word.
REQ-013 cfg_update  output  1  one-cycle pulse on the cycle committed outputs change.
REQ-014 cfg_error  output  1  sticky malformed-frame flag; cleared by the next frame_start.
REQ-015 busy  output  1  high while a frame is open (state not IDLE).

Function
REQ-016 FSM states: IDLE, CTRL, FREQ, DUTY, DONE, ERR.
REQ-017 frame_start from any state: clear shadow registers and byte counter, clear cfg_error, go to CTRL; rx_valid in the same cycle is dropped.
REQ-018 CTRL, rx_valid: latch ctrl byte into shadow. Bit0 = enable, bits[2:1] = wave, bit4 = frequency follows, bit5 = duty follows, bits 3, 6 and 7 ignored.
REQ-019 From CTRL, the next state is FREQ if bit4 is set, else DUTY if bit5 is set, else DONE.
REQ-020 FREQ: 8 bytes shift into shadow frequency, MSB byte first. The 3-bit counter wraps 7->0 on the 8th byte; the next state is then DUTY if bit5 is set, else DONE.
REQ-021 DUTY: 2 bytes shift into shadow duty, MSB byte first; then go to DONE.
REQ-022 DONE, rx_valid: extra byte -> ERR and cfg_error=1.
REQ-023 frame_stop in DONE: on the next clock, copy shadow into committed outputs (enable and wave always; frequency/duty only if the flag bit was set) and pulse cfg_update for that same cycle; go to IDLE.
REQ-024 frame_stop in FREQ or DUTY (truncated frame): no commit, cfg_error=1, go to IDLE.
REQ-025 frame_stop in CTRL (address-only frame): no commit, no error, go to IDLE.
REQ-026 frame_stop in ERR: no commit, go to IDLE; cfg_error stays set.
REQ-027 rx_valid and frame_stop in the same cycle: process the byte first, then evaluate the stop against the resulting state.
REQ-028 rx_valid or frame_stop in IDLE: ignored.
REQ-029 Committed outputs change only at a commit, so a half-received frame never reaches the NCO.

Reset
REQ-030 On rst low, immediately:
- state = IDLE, counter = 0, shadow cleared.
- nco_enable = 0, wave = 2'b00.
- frequency = FREQ_RST, duty_cycle = DUTY_RST.
- cfg_update = 0, cfg_error = 0, busy = 0.
REQ-031 Reset asserted mid-frame discards the frame with no commit; operation resumes on the first clock edge after rst deasserts.

Configuration
REQ-032 Macro NCO_CFG_DUTY_EN defined: bit5 and the DUTY state behave as specified above.
REQ-033 Macro NCO_CFG_DUTY_EN undefined:
- DUTY state is not built and bit5 is ignored.
- duty_cycle is held constant at DUTY_RST.
- A frame with bit5 set goes to DONE after the ctrl/frequency bytes; any trailing duty bytes set cfg_error.

Verification
REQ-034 Start, ctrl 8'h05, stop -> one clock after stop: nco_enable=1, wave=2'b10, frequency unchanged, single cfg_update pulse.
REQ-035 Start, ctrl 8'h11, freq 64'h0001_D4C0_0000_0000, stop -> nco_enable=1, wave=0, frequency=64'h0001_D4C0_0000_0000, cfg_update one cycle.
REQ-036 Start, ctrl 8'h11, only 3 freq bytes, stop -> cfg_error=1, all outputs unchanged, no cfg_update.
REQ-037 With NCO_CFG_DUTY_EN: start, ctrl 8'h31, 8 freq bytes, duty 16'h4000, stop -> frequency and duty_cycle=16'h4000 commit together. Without the macro, the same stimulus -> cfg_error=1 and duty_cycle stays at DUTY_RST.
REQ-038 Repeated start after 4 freq bytes, then a full 8'h01 frame and stop -> only enable commits, frequency unchanged, cfg_error=0.
REQ-039 rst pulsed low after the 5th freq byte -> outputs return to reset values at once; a later stop produces no cfg_update.
